// File: rtl/bcd_cnt_n.sv
// bcd_cnt_n: multi-digit up/down counter with a configurable digit base.
// Every digit is 4 bits wide and counts modulo BASE (decimal by default).
// All digits step in the same cycle; the carry/borrow chain is resolved
// combinationally from the current value, so there is no ripple latency.
// Loads replace any digit >= BASE with 0 and flag it on lerr.
// Optional build macro BCDN_SAT_EN: the counter saturates at its end values
// instead of wrapping (co still pulses on every blocked count edge).
module bcd_cnt_n #(
    parameter int DIGITS = 4,   // 1..8
    parameter int BASE   = 10   // 2..16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  clr,
    input  logic                  updown,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   din,
    output logic [4*DIGITS-1:0]   q,
    output logic                  co,
    output logic [DIGITS-1:0]     dco,
    output logic                  lerr
);

    localparam logic [3:0] DMAX  = 4'(BASE - 1);
    localparam logic [4:0] DBASE = 5'(BASE);

    logic [4*DIGITS-1:0] q_q, q_d;
    logic                co_q, co_d;
    logic [DIGITS-1:0]   dco_q, dco_d;
    logic                lerr_q, lerr_d;

    logic [4*DIGITS-1:0] load_val;
    logic                load_bad;
    logic [4*DIGITS-1:0] cnt_val;
    logic [DIGITS-1:0]   cnt_dco;
    logic                cnt_wrap;

    // Scrub illegal load digits to zero and note whether any were found
    always_comb begin
        load_val = '0;
        load_bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if ({1'b0, din[4*i +: 4]} >= DBASE) begin
                load_bad = 1'b1;
            end else begin
                load_val[4*i +: 4] = din[4*i +: 4];
            end
        end
    end

    // Carry/borrow chain: a digit steps only while every lower digit wrapped
    always_comb begin
        logic chain;
        chain   = 1'b1;
        cnt_val = q_q;
        cnt_dco = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (chain) begin
                if (!updown) begin
                    if (q_q[4*i +: 4] == DMAX) begin
                        cnt_val[4*i +: 4] = 4'd0;
                        cnt_dco[i]        = 1'b1;
                    end else begin
                        cnt_val[4*i +: 4] = q_q[4*i +: 4] + 4'd1;
                        chain             = 1'b0;
                    end
                end else begin
                    if (q_q[4*i +: 4] == 4'd0) begin
                        cnt_val[4*i +: 4] = DMAX;
                        cnt_dco[i]        = 1'b1;
                    end else begin
                        cnt_val[4*i +: 4] = q_q[4*i +: 4] - 4'd1;
                        chain             = 1'b0;
                    end
                end
            end
        end
        // chain still set means every digit wrapped: whole-counter wrap
        cnt_wrap = chain;
    end

    // Next state: clr, then load, then count, then hold; pulses default low
    always_comb begin
        q_d    = q_q;
        co_d   = 1'b0;
        dco_d  = '0;
        lerr_d = lerr_q;
        if (clr) begin
            q_d    = '0;
            lerr_d = 1'b0;
        end else if (en && load) begin
            q_d    = load_val;
            lerr_d = load_bad;
        end else if (en) begin
`ifdef BCDN_SAT_EN
            if (cnt_wrap) begin
                co_d = 1'b1;
            end else begin
                q_d   = cnt_val;
                dco_d = cnt_dco;
            end
`else
            q_d   = cnt_val;
            dco_d = cnt_dco;
            co_d  = cnt_wrap;
`endif
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_q    <= '0;
            co_q   <= 1'b0;
            dco_q  <= '0;
            lerr_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            co_q   <= co_d;
            dco_q  <= dco_d;
            lerr_q <= lerr_d;
        end
    end

    assign q    = q_q;
    assign co   = co_q;
    assign dco  = dco_q;
    assign lerr = lerr_q;

endmodule

// File: tb/tb_bcd_cnt_n.sv
// Bench for bcd_cnt_n: three instances (4 digits base 10, 2 digits base 16,
// 1 digit base 2) checked every cycle against an integer-valued model, plus
// literal expectations for the hand-worked scenarios.
module tb_bcd_cnt_n;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        en_x   [3];
    logic        clr_x  [3];
    logic        ud_x   [3];
    logic        load_x [3];
    logic [31:0] din_x  [3];

    logic [15:0] q_a;  logic co_a; logic [3:0] dco_a; logic lerr_a;
    logic [7:0]  q_b;  logic co_b; logic [1:0] dco_b; logic lerr_b;
    logic [3:0]  q_c;  logic co_c; logic [0:0] dco_c; logic lerr_c;

    int nchk = 0;
    int nerr = 0;
    logic chk_en = 1'b0;

    bcd_cnt_n #(.DIGITS(4), .BASE(10)) dut_a (
        .clk(clk), .rst(rst), .en(en_x[0]), .clr(clr_x[0]), .updown(ud_x[0]),
        .load(load_x[0]), .din(din_x[0][15:0]), .q(q_a), .co(co_a), .dco(dco_a), .lerr(lerr_a));
    bcd_cnt_n #(.DIGITS(2), .BASE(16)) dut_b (
        .clk(clk), .rst(rst), .en(en_x[1]), .clr(clr_x[1]), .updown(ud_x[1]),
        .load(load_x[1]), .din(din_x[1][7:0]), .q(q_b), .co(co_b), .dco(dco_b), .lerr(lerr_b));
    bcd_cnt_n #(.DIGITS(1), .BASE(2)) dut_c (
        .clk(clk), .rst(rst), .en(en_x[2]), .clr(clr_x[2]), .updown(ud_x[2]),
        .load(load_x[2]), .din(din_x[2][3:0]), .q(q_c), .co(co_c), .dco(dco_c), .lerr(lerr_c));

    function automatic int base_of(input int k);
        return (k == 0) ? 10 : (k == 1) ? 16 : 2;
    endfunction

    function automatic int dig_of(input int k);
        return (k == 0) ? 4 : (k == 1) ? 2 : 1;
    endfunction

    function automatic longint modv(input int k);
        longint r = 1;
        for (int i = 0; i < dig_of(k); i++) r = r * base_of(k);
        return r;
    endfunction

    // Model state: the counter as a plain integer in [0, BASE**DIGITS)
    typedef struct packed {
        longint     v;
        logic       co;
        logic [7:0] dco;
        logic       lerr;
    } mst_t;

    mst_t m [3];

    function automatic logic [31:0] to_q(input int k, input longint v);
        logic [31:0] r = '0;
        longint      x = v;
        for (int i = 0; i < dig_of(k); i++) begin
            r[4*i +: 4] = 4'(x % base_of(k));
            x = x / base_of(k);
        end
        return r;
    endfunction

    function automatic mst_t step(input int k, input mst_t s, input logic c, input logic e,
                                  input logic l, input logic u, input logic [31:0] d);
        int     b    = base_of(k);
        int     n    = dig_of(k);
        longint mx   = modv(k);
        longint p;
        int     dd;
        logic   wrap;
        mst_t   r;
        r     = s;
        r.co  = 1'b0;
        r.dco = '0;
        if (c) begin
            r.v    = 0;
            r.lerr = 1'b0;
        end else if (e && l) begin
            r.v    = 0;
            r.lerr = 1'b0;
            p      = 1;
            for (int i = 0; i < n; i++) begin
                dd = int'(d[4*i +: 4]);
                if (dd >= b) begin
                    r.lerr = 1'b1;
                    dd     = 0;
                end
                r.v = r.v + dd * p;
                p   = p * b;
            end
        end else if (e) begin
            // digit i wraps when the value of digits 0..i is all-max (up) or all-zero (down)
            p = b;
            for (int i = 0; i < n; i++) begin
                if (!u ? (s.v % p == p - 1) : (s.v % p == 0)) r.dco[i] = 1'b1;
                p = p * b;
            end
            wrap = !u ? (s.v == mx - 1) : (s.v == 0);
            if (wrap) begin
                r.co = 1'b1;
`ifdef BCDN_SAT_EN
                r.dco = '0;
                r.v   = s.v;
`else
                r.v = u ? mx - 1 : 0;
`endif
            end else begin
                r.v = u ? s.v - 1 : s.v + 1;
            end
        end
        return r;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < 3; k++) m[k] <= '0;
        end else begin
            for (int k = 0; k < 3; k++)
                m[k] <= step(k, m[k], clr_x[k], en_x[k], load_x[k], ud_x[k], din_x[k]);
        end
    end

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            cmp("model q_a",    32'(q_a),    to_q(0, m[0].v));
            cmp("model co_a",   32'(co_a),   32'(m[0].co));
            cmp("model dco_a",  32'(dco_a),  32'(m[0].dco));
            cmp("model lerr_a", 32'(lerr_a), 32'(m[0].lerr));
            cmp("model q_b",    32'(q_b),    to_q(1, m[1].v));
            cmp("model co_b",   32'(co_b),   32'(m[1].co));
            cmp("model dco_b",  32'(dco_b),  32'(m[1].dco));
            cmp("model lerr_b", 32'(lerr_b), 32'(m[1].lerr));
            cmp("model q_c",    32'(q_c),    to_q(2, m[2].v));
            cmp("model co_c",   32'(co_c),   32'(m[2].co));
            cmp("model dco_c",  32'(dco_c),  32'(m[2].dco));
            cmp("model lerr_c", 32'(lerr_c), 32'(m[2].lerr));
        end
    end

    // Drive one instance for one edge (others idle), return at the next falling edge
    task automatic cyc(input int k, input logic c, input logic e, input logic l,
                       input logic u, input logic [31:0] d);
        for (int j = 0; j < 3; j++) begin
            clr_x[j]  = 1'b0;
            en_x[j]   = 1'b0;
            load_x[j] = 1'b0;
        end
        clr_x[k]  = c;
        en_x[k]   = e;
        load_x[k] = l;
        ud_x[k]   = u;
        din_x[k]  = d;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            en_x[k] = 1'b0; clr_x[k] = 1'b0; ud_x[k] = 1'b0; load_x[k] = 1'b0; din_x[k] = '0;
        end
        repeat (3) @(negedge clk);
        rst    = 1'b1;
        chk_en = 1'b1;
        cmp("reset q",    32'(q_a),    32'h0);
        cmp("reset co",   32'(co_a),   32'h0);
        cmp("reset dco",  32'(dco_a),  32'h0);
        cmp("reset lerr", 32'(lerr_a), 32'h0);

        cyc(0, 0, 1, 1, 0, 32'h0999);
        cmp("load 0999", 32'(q_a), 32'h0999);
        cyc(0, 0, 1, 0, 0, 32'h0);
        cmp("cascade q",   32'(q_a),   32'h1000);
        cmp("cascade dco", 32'(dco_a), 32'h7);
        cmp("cascade co",  32'(co_a),  32'h0);
        cyc(0, 0, 0, 0, 0, 32'h0);
        cmp("cascade dco clears", 32'(dco_a), 32'h0);
        cmp("hold q",             32'(q_a),   32'h1000);

        cyc(0, 0, 1, 1, 0, 32'h0);
        cyc(0, 0, 1, 0, 1, 32'h0);
`ifdef BCDN_SAT_EN
        cmp("down sat q",   32'(q_a),   32'h0000);
        cmp("down sat co",  32'(co_a),  32'h1);
        cmp("down sat dco", 32'(dco_a), 32'h0);
`else
        cmp("down wrap q",   32'(q_a),   32'h9999);
        cmp("down wrap co",  32'(co_a),  32'h1);
        cmp("down wrap dco", 32'(dco_a), 32'hF);
`endif
        cyc(0, 0, 0, 0, 0, 32'h0);
        cmp("co one cycle", 32'(co_a), 32'h0);

        cyc(0, 0, 1, 1, 0, 32'h3A7F);
        cmp("illegal load q",    32'(q_a),    32'h3070);
        cmp("illegal load lerr", 32'(lerr_a), 32'h1);
        cyc(0, 0, 1, 1, 0, 32'h1234);
        cmp("legal load q",    32'(q_a),    32'h1234);
        cmp("legal load lerr", 32'(lerr_a), 32'h0);
        cyc(0, 0, 0, 1, 0, 32'h3A7F);
        cmp("load en=0 q",    32'(q_a),    32'h1234);
        cmp("load en=0 lerr", 32'(lerr_a), 32'h0);

        cyc(0, 1, 1, 1, 0, 32'h5555);
        cmp("clr beats load", 32'(q_a), 32'h0);
        cyc(0, 0, 1, 1, 0, 32'h1234);
        cyc(0, 1, 0, 0, 0, 32'h0);
        cmp("clr en=0", 32'(q_a), 32'h0);

        // asynchronous reset between edges while counting
        cyc(0, 0, 1, 1, 0, 32'h0357);
        cmp("pre-reset q", 32'(q_a), 32'h0357);
        load_x[0] = 1'b0;
        en_x[0]   = 1'b1;
        #3 rst = 1'b0;
        #1;
        cmp("async reset q",    32'(q_a),    32'h0);
        cmp("async reset co",   32'(co_a),   32'h0);
        cmp("async reset dco",  32'(dco_a),  32'h0);
        cmp("async reset lerr", 32'(lerr_a), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        cyc(0, 0, 1, 0, 0, 32'h0);
        cmp("first count after reset", 32'(q_a), 32'h0001);

        cyc(1, 0, 1, 1, 0, 32'hFE);
        cyc(1, 0, 1, 0, 0, 32'h0);
        cmp("base16 q FF", 32'(q_b), 32'hFF);
        cmp("base16 co 0", 32'(co_b), 32'h0);
        cyc(1, 0, 1, 0, 0, 32'h0);
`ifdef BCDN_SAT_EN
        cmp("base16 sat q", 32'(q_b), 32'hFF);
`else
        cmp("base16 wrap q", 32'(q_b), 32'h00);
`endif
        cmp("base16 co", 32'(co_b), 32'h1);

        cyc(2, 0, 1, 1, 0, 32'h0);
        cyc(2, 0, 1, 0, 1, 32'h0);
        cmp("base2 co first", 32'(co_c), 32'h1);
`ifdef BCDN_SAT_EN
        cyc(2, 0, 1, 0, 1, 32'h0);
`else
        cyc(2, 0, 1, 0, 0, 32'h0);
`endif
        cmp("base2 co back-to-back", 32'(co_c), 32'h1);

        repeat (3000) begin
            for (int k = 0; k < 3; k++) begin
                int sel;
                clr_x[k]  = ($urandom_range(0, 39) == 0);
                en_x[k]   = ($urandom_range(0, 4) != 0);
                load_x[k] = ($urandom_range(0, 9) == 0);
                if ($urandom_range(0, 7) == 0) ud_x[k] = ~ud_x[k];
                sel = int'($urandom_range(0, 3));
                if (sel == 0)      din_x[k] = to_q(k, modv(k) - 1);
                else if (sel == 1) din_x[k] = '0;
                else               din_x[k] = $urandom;
            end
            @(posedge clk);
            @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule

// File: doc/bcd_cnt_n.md
# bcd_cnt_n

Parametrised multi-digit up/down counter with a configurable digit base (BCD by default). Each digit is 4 bits, and digits cascade through an internal carry/borrow chain. The block adds synchronous load with per-digit legality checking, synchronous clear, per-digit carry visibility and a load-error flag. It serves as the general event/time counter for display and timing paths, replacing single-digit counters chained by hand.

## Interface
Parameters:
- DIGITS, 4: number of 4-bit digits; legal range 1..8.
- BASE, 10: modulus of every digit; legal range 2..16.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  count/load enable.
- clr  in  1  synchronous clear; independent of en.
- updown  in  1  count direction: 0 = up, 1 = down.
- load  in  1  parallel load; takes effect only when en=1.
- din  in  4*DIGITS  load value; digit i is din[4i+3:4i].
- q  out  4*DIGITS  counter value; digit i is q[4i+3:4i], digit 0 is least significant.
- co  out  1  registered whole-counter carry/borrow (or saturation) pulse.
- dco  out  DIGITS  registered per-digit carry/borrow flags.
- lerr  out  1  registered flag: the last load contained an illegal digit.

## Operation
Reset (rst=0, asynchronous): q=0, co=0, dco=0, lerr=0. The reset is held regardless of clk.

Priority at each rising edge: clr, then en&load, then en&count, then hold.
- clr=1: q=0, co=0, dco=0, lerr=0.
- en=1, load=1:
  - Each digit of din with value ≥ BASE is replaced by 0. All other digits load unchanged.
  - lerr=1 if any digit was replaced, else lerr=0.
  - co=0, dco=0.
- en=1, load=0, updown=0 (up):
  - Digit 0 increments.
  - Digit i increments only when all lower digits equal BASE-1.
  - A digit at BASE-1 that increments wraps to 0, and its dco[i]=1.
  - When all digits equal BASE-1, q wraps to all-zero and co=1.
- en=1, load=0, updown=1 (down):
  - Digit 0 decrements.
  - Digit i decrements only when all lower digits equal 0.
  - A digit at 0 that decrements wraps to BASE-1, and its dco[i]=1.
  - When q is all-zero, it wraps to all digits BASE-1 and co=1.
- en=0, clr=0: q holds, co=0, dco=0, lerr holds.
- co and dco are cleared on every edge where they are not set, so each is a one-cycle pulse per event.
- lerr holds until the next load, clr or reset.
- Out-of-range q: digits can only reach values ≥ BASE through illegal loads, which are scrubbed, so q never holds such a digit.
- Arithmetic: each digit is 4 bits and never exceeds BASE-1. The carry chain is purely combinational from the current q within a single cycle; there is no ripple latency across digits.

## Timing
- All outputs are registered and update on the rising edge of clk; there is no combinational input-to-output path.
- Count and load latency is 1 cycle.
- co goes high in the cycle following the wrapping edge and stays high for exactly one cycle.
- Back-to-back wraps (e.g. DIGITS=1, BASE=2) produce co high on consecutive cycles.
- Reversing updown mid-count takes effect on the next enabled edge; there is no pipeline to flush.
- Reset asserted mid-count immediately forces all outputs to their reset values.
- On the first edge after rst rises, normal priority applies.
- clr=1 together with load=1 (or with a count): clr wins, and din is ignored.

## Configuration
- BCDN_SAT_EN defined: the counter saturates instead of wrapping.
  - Up at all digits BASE-1: q holds and co=1 for each enabled count edge.
  - Down at all-zero: q holds and co=1 for each enabled count edge.
  - dco=0 on a saturating edge.
  - Carries within the range (e.g. 0099 up to 0100) still set dco normally.
- BCDN_SAT_EN undefined: wrap-around behaviour as described under Operation.

## Test plan
All scenarios use default parameters (DIGITS=4, BASE=10) unless stated.
- Reset: drive rst=0 mid-count with q=0x0357 → q=0x0000, co=0, dco=0, lerr=0 immediately, without waiting for a clk edge.
- Up cascade: load 0x0999, then one up count → q=0x1000, dco=4'b0111, co=0; next edge dco=0.
- Down wrap: load 0x0000, then one down count → q=0x9999, co=1 for one cycle, dco=4'b1111. With BCDN_SAT_EN defined → q=0x0000, co=1, dco=0.
- Illegal load:
  - en=1, load=1, din=0x3A7F → q=0x3070, lerr=1.
  - Then load 0x1234 → lerr=0.
  - With en=0, the same load → q unchanged.
- Priority: clr=1 with load=1, din=0x5555 → q=0x0000. With en=0 and clr=1 → q=0x0000.
- Non-BCD base: with DIGITS=2 and BASE=16, count up from 0xFE for two edges → q=0xFF, then q=0x00 with co=1.
